// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG-to-AXI4-Lite master controller.
//   axi_status_t    : 3-bit result code reported on txn_status
//   axi_ctrl_fsm_t  : controller state encoding
//   AXI_RESP_*      : AXI4-Lite BRESP/RRESP encodings
//   resp_to_status  : folds an AXI response into an axi_status_t
package jtag_pkg;

    typedef enum logic [2:0] {
        STAT_IDLE    = 3'd0,
        STAT_RUNNING = 3'd1,
        STAT_OKAY    = 3'd2,
        STAT_SLVERR  = 3'd3,
        STAT_DECERR  = 3'd4,
        STAT_TIMEOUT = 3'd5
    } axi_status_t;

    typedef enum logic [2:0] {
        FSM_IDLE    = 3'd0,
        FSM_WR_REQ  = 3'd1,
        FSM_WR_RESP = 3'd2,
        FSM_RD_REQ  = 3'd3,
        FSM_RD_RESP = 3'd4
    } axi_ctrl_fsm_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // EXOKAY is folded into OKAY: the JTAG side has no exclusive-access notion.
    function automatic axi_status_t resp_to_status(input logic [1:0] resp);
        axi_status_t st;
        case (resp)
            AXI_RESP_OKAY:   st = STAT_OKAY;
            AXI_RESP_EXOKAY: st = STAT_OKAY;
            AXI_RESP_SLVERR: st = STAT_SLVERR;
            AXI_RESP_DECERR: st = STAT_DECERR;
            default:         st = STAT_DECERR;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/jtag_axi_master_ctrl.sv
// JTAG-driven AXI4-Lite single-transaction master.
// A one-cycle txn_valid pulse (from the JTAG update stage) launches one AXI4-Lite
// read or write; the result is reported on txn_status / txn_rdata and held until
// the next accepted request. Requests arriving while busy are dropped.
// Optional build macro: JTAG_AXI_TIMEOUT_EN adds the TIMEOUT_CYCLES parameter and
// an abort counter that returns the controller to IDLE with status TIMEOUT.
// Ports:
//   tck, trstn                         clock, synchronous active-low reset
//   txn_valid/write/addr/wdata/wstrb   request from the JTAG data registers
//   txn_busy, txn_rdata, txn_status    request status back to JTAG
//   aw*/w*/b*/ar*/r*                   AXI4-Lite master channels (prot tied to 0)
module jtag_axi_master_ctrl
    import jtag_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
`ifdef JTAG_AXI_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                    tck,
    input  logic                    trstn,
    input  logic                    txn_valid,
    input  logic                    txn_write,
    input  logic [ADDR_WIDTH-1:0]   txn_addr,
    input  logic [DATA_WIDTH-1:0]   txn_wdata,
    input  logic [DATA_WIDTH/8-1:0] txn_wstrb,
    output logic                    txn_busy,
    output logic [DATA_WIDTH-1:0]   txn_rdata,
    output logic [2:0]              txn_status,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready
);

    axi_ctrl_fsm_t           state_r;
    axi_status_t             status_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic [ADDR_WIDTH-1:0]   awaddr_r;
    logic [ADDR_WIDTH-1:0]   araddr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH/8-1:0] wstrb_r;
    logic                    awvalid_r;
    logic                    wvalid_r;
    logic                    bready_r;
    logic                    arvalid_r;
    logic                    rready_r;
    logic                    tmo_hit_s;

`ifdef JTAG_AXI_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // Flags the last permitted busy cycle; the FSM aborts on the edge that ends it.
    always_comb begin
        tmo_hit_s = (state_r != FSM_IDLE) && (tmo_cnt_r == TMO_LAST);
    end

    // Busy-cycle counter: zero in IDLE (hence at acceptance), counts every busy cycle.
    always_ff @(posedge tck) begin
        if (!trstn) begin
            tmo_cnt_r <= '0;
        end else if (state_r == FSM_IDLE || tmo_hit_s) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end
`else
    // No abort path: the controller waits on the slave indefinitely.
    always_comb begin
        tmo_hit_s = 1'b0;
    end
`endif

    // Transaction FSM with all AXI and status outputs registered.
    always_ff @(posedge tck) begin
        if (!trstn) begin
            state_r   <= FSM_IDLE;
            status_r  <= STAT_IDLE;
            rdata_r   <= '0;
            awaddr_r  <= '0;
            araddr_r  <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
        end else if (tmo_hit_s) begin
            // Abort wins over any handshake landing on the same edge.
            state_r   <= FSM_IDLE;
            status_r  <= STAT_TIMEOUT;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
        end else begin
            case (state_r)
                FSM_IDLE: begin
                    if (txn_valid) begin
                        // Latch the whole request so AXI payloads stay stable under valid.
                        awaddr_r <= txn_addr;
                        araddr_r <= txn_addr;
                        wdata_r  <= txn_wdata;
                        wstrb_r  <= txn_wstrb;
                        status_r <= STAT_RUNNING;
                        if (txn_write) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= FSM_WR_REQ;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= FSM_RD_REQ;
                        end
                    end
                end
                FSM_WR_REQ: begin
                    if (awvalid_r && awready) begin
                        awvalid_r <= 1'b0;
                    end
                    if (wvalid_r && wready) begin
                        wvalid_r <= 1'b0;
                    end
                    // A channel is finished if it already handshook or handshakes now.
                    if ((!awvalid_r || awready) && (!wvalid_r || wready)) begin
                        bready_r <= 1'b1;
                        state_r  <= FSM_WR_RESP;
                    end
                end
                FSM_WR_RESP: begin
                    if (bvalid) begin
                        bready_r <= 1'b0;
                        status_r <= resp_to_status(bresp);
                        state_r  <= FSM_IDLE;
                    end
                end
                FSM_RD_REQ: begin
                    if (arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= FSM_RD_RESP;
                    end
                end
                FSM_RD_RESP: begin
                    if (rvalid) begin
                        rready_r <= 1'b0;
                        rdata_r  <= rdata;
                        status_r <= resp_to_status(rresp);
                        state_r  <= FSM_IDLE;
                    end
                end
                default: begin
                    state_r   <= FSM_IDLE;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign txn_busy   = (state_r != FSM_IDLE);
    assign txn_rdata  = rdata_r;
    assign txn_status = status_r;
    assign awaddr     = awaddr_r;
    assign awprot     = 3'b000;
    assign awvalid    = awvalid_r;
    assign wdata      = wdata_r;
    assign wstrb      = wstrb_r;
    assign wvalid     = wvalid_r;
    assign bready     = bready_r;
    assign araddr     = araddr_r;
    assign arprot     = 3'b000;
    assign arvalid    = arvalid_r;
    assign rready     = rready_r;

endmodule

// File: doc/jtag_axi_master_ctrl.md
JTAG_AXI_MASTER_CTRL -- requirements
Module: jtag_axi_master_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH  32  AXI4-Lite address width
  DATA_WIDTH  32  AXI4-Lite data width; STRB width = DATA_WIDTH/8
  TIMEOUT_CYCLES  4096  cycles in a non-IDLE state before abort (timeout build only)
REQ-002 Ports SHALL be, one per line:
  tck  in  1  single clock
  trstn  in  1  reset; synchronous, active-low
  txn_valid  in  1  one-cycle request pulse from the JTAG data registers (axi_update)
  txn_write  in  1  1 = write, 0 = read
  txn_addr  in  ADDR_WIDTH  target address
  txn_wdata / txn_wstrb  in  DATA_WIDTH / STRB  write payload
  txn_busy  out  1  transaction in flight
  txn_rdata  out  DATA_WIDTH  last read data
  txn_status  out  3  axi_status_t result
  awaddr, awvalid / awready  out, out / in  ADDR_WIDTH, 1 / 1  write-address channel
  wdata, wstrb, wvalid / wready  out / in  DATA_WIDTH, STRB, 1 / 1  write-data channel
  bresp, bvalid / bready  in / out  2, 1 / 1  write-response channel
  araddr, arvalid / arready  out / in  ADDR_WIDTH, 1 / 1  read-address channel
  rdata, rresp, rvalid / rready  in / out  DATA_WIDTH, 2, 1 / 1  read-data channel
  (awprot/arprot SHALL be tied to 3'b000)

Function
REQ-003 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
REQ-004 txn_valid SHALL be sampled only in IDLE; on acceptance all txn_* inputs latch, txn_status becomes RUNNING, next state is WR_REQ or RD_REQ.
REQ-005 txn_valid outside IDLE SHALL be ignored, with no effect on state, outputs or latched fields.
REQ-006 txn_busy SHALL be 1 in every state except IDLE.
REQ-007 In WR_REQ, awvalid and wvalid SHALL rise together on the cycle after acceptance; each drops on its own ready handshake; the FSM enters WR_RESP once both handshakes are done (same-cycle awready+wready allowed).
REQ-008 In WR_RESP, bready SHALL be 1; on bvalid the FSM returns to IDLE and bresp maps to txn_status.
REQ-009 In RD_REQ, arvalid SHALL be 1 until arready; RD_RESP then asserts rready until rvalid, capturing rdata into txn_rdata and mapping rresp.
REQ-010 Response mapping SHALL be: OKAY/EXOKAY -> OKAY(2), SLVERR -> SLVERR(3), DECERR -> DECERR(4); status codes IDLE=0, RUNNING=1, TIMEOUT=5.
REQ-011 txn_status and txn_rdata SHALL hold until the next accepted request; writes never modify txn_rdata.
REQ-012 With zero-wait slaves, minimum latency from the txn_valid edge to IDLE SHALL be 3 cycles for both writes and reads.
REQ-013 bready/rready SHALL never assert outside WR_RESP/RD_RESP.
REQ-014 AXI address/data outputs SHALL be stable while the matching valid is high.

Reset
REQ-015 When trstn=0 at a tck edge: state IDLE; all valid/ready outputs 0; txn_busy 0; txn_status IDLE; txn_rdata, awaddr, araddr, wdata 0; wstrb 0.
REQ-016 Reset mid-transaction SHALL abort immediately without waiting for handshakes; the interconnect is reset in the same domain.

Configuration
REQ-017 With JTAG_AXI_TIMEOUT_EN defined, a counter SHALL clear on acceptance and increment each non-IDLE cycle; at TIMEOUT_CYCLES it forces all valid/ready to 0, status TIMEOUT, and state IDLE on the next edge.
REQ-018 Without JTAG_AXI_TIMEOUT_EN, no counter SHALL exist, the FSM waits indefinitely, and TIMEOUT is never produced.

Structure
REQ-019 jtag_pkg SHALL hold axi_status_t (3-bit enum), axi_ctrl_fsm_t, and the AXI response constants.
REQ-020 The block SHALL be flat with no sub-module; wiring into jtag_wrapper consumes axi_info/axi_update.

Verification
REQ-021 Write 0xDEADBEEF to 0x1000, wstrb 0xF, zero-wait slave, bresp OKAY -> awvalid/wvalid high for 1 cycle, status 2, busy low 3 cycles after the pulse.
REQ-022 Read 0x2000, arready delayed 4 cycles, rdata 0xCAFEF00D, rresp SLVERR -> arvalid held 5 cycles, txn_rdata 0xCAFEF00D, status 3.
REQ-023 Write with wready 2 cycles before awready -> wvalid drops first, awvalid holds, exactly one handshake each, then WR_RESP.
REQ-024 Second txn_valid during a read -> ignored; latched addr unchanged; only one AR handshake.
REQ-025 trstn low mid WR_RESP -> next edge all valid/ready 0, status 0, busy 0.
REQ-026 With JTAG_AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready stuck 0 -> arvalid drops after 16 cycles, status 5, IDLE.
